sort_output_checker: RTL and testbench
======================================

// Module: sort_output_checker
// PURPOSE
//  Self-checking stage directly downstream of the bubble sorter. It snoops the
//  sorter's put stream and drains the sorter's get stream. It checks that
//  outputs are non-decreasing, that the output count matches the input count,
//  and that the sums match (multiset sanity check). It reports a sticky
//  pass/fail verdict for the testbench to act on.
// PARAMETERS
//  N        5    items per sort batch; both input and output counts must equal N
//  W        32   data width, matching the sorter's put_x/get ports
//  SW       40   accumulator width for input/output sums (>= W + clog2(N))
//  TIMEOUT  64   watchdog limit in cycles; used only with SORT_CHK_TIMEOUT_EN
// PORTS
//  CLK          in   1   clock
//  RST_N        in   1   reset, synchronous, active-low
//  in_en        in   1   sorter EN_put; a put occurs this cycle
//  in_x         in   W   sorter put_x, valid when in_en=1
//  out_rdy      in   1   sorter RDY_get
//  out_y        in   W   sorter get value, valid when out_rdy=1
//  get_en       out  1   drives sorter EN_get; combinational
//  done         out  1   verdict valid; sticky until reset
//  pass         out  1   1 = batch correct; valid only when done=1
//  err_order    out  1   sticky; an output was smaller than its predecessor
//  err_count    out  1   sticky; >N inputs, or a get with out_cnt >= in_cnt
//  err_sum      out  1   set at completion when sum_in != sum_out
//  err_timeout  out  1   sticky watchdog flag; tied to 0 without the macro
//  out_cnt      out  8   number of items drained so far
// BEHAVIOUR
//  - Reset (RST_N=0 at posedge): clears all registers. Outputs after reset:
//    get_en=0 (while out_rdy=0), done=0, pass=0, all err_*=0, out_cnt=0,
//    in_cnt=0, sums=0, prev_y=0, state=RUN.
//    Reset mid-batch discards all progress with no partial verdict.
//  - States: RUN, DONE.
//    RUN->DONE on the cycle of the N-th get, or on timeout.
//    DONE is held until reset.
//  - get_en = out_rdy && state==RUN && out_cnt<N. It is a pure function of
//    the current inputs and state; the block never holds off a ready output.
//  - Input snoop (any state except DONE):
//    - in_en && in_cnt<N: in_cnt++, sum_in += zero-extended in_x.
//    - in_en && in_cnt==N: set err_count; value ignored.
//  - Each get (get_en=1): sum_out += out_y, prev_y <= out_y, out_cnt++.
//    - out_cnt>0 && out_y < prev_y (unsigned compare): set err_order.
//    - out_cnt >= in_cnt, counting a same-cycle in_en: set err_count.
//  - Same-cycle put and get are both processed. in_cnt and sum_in use the
//    incoming put before the count check for that get.
//  - Completion, registered on the N-th get edge, so done rises 1 cycle
//    after that get:
//    - err_sum <= (sum_in_next != sum_out + out_y).
//    - pass <= !err_order_next && !err_count_next && !err_sum_next &&
//      !err_timeout && in_cnt_next==N.
//  - Accumulators never wrap for N*2^W < 2^SW. Implementations must
//    statically check SW >= W+clog2(N+1).
//  - out_cnt saturates at N; get_en=0 thereafter.
// CONFIGURATION
//  SORT_CHK_TIMEOUT_EN defined:
//    - A wdog counter clears on every put or get and increments in RUN once
//      in_cnt>0.
//    - When it reaches TIMEOUT: err_timeout=1, state->DONE, pass=0, done
//      rises the next cycle.
//    - wdog holds in DONE.
//  Not defined: no wdog logic; err_timeout is tied to 0; a stalled sorter
//  leaves done=0 indefinitely.
// TESTING
//  1. Nominal: inputs 1,142,71,173,216 (LFSR seed 1); outputs
//     1,71,142,173,216 -> done=1, pass=1, all err_*=0, out_cnt=5.
//  2. Order fault: outputs 1,142,71,173,216 -> err_order=1 at the 3rd get,
//     done=1, pass=0, err_sum=0.
//  3. Sum fault: inputs as in (1); outputs 1,71,142,173,217 -> err_sum=1,
//     err_order=0, pass=0.
//  4. Early output: out_rdy=1, out_y=5 before any in_en -> err_count=1
//     immediately. After a complete batch: pass=0.
//  5. Overflow and simultaneity: 6th in_en -> err_count=1. Put and get in
//     the same cycle, with in_cnt going 4->5 and out_cnt=4 -> no err_count.
//  6. Reset and watchdog: RST_N=0 after 3 gets -> next cycle all outputs are
//     0, then the full batch passes. With SORT_CHK_TIMEOUT_EN, 5 puts and
//     out_rdy held 0 for 64 cycles -> err_timeout=1, done=1, pass=0.

Source files
------------

// File: rtl/sort_output_checker.sv
// sort_output_checker
//   Sits downstream of the bubble sorter. It snoops the put stream and drains
//   the get stream. It checks that the drained values are non-decreasing, that
//   the put and get counts agree, and that the two value sums match. The
//   verdict (done/pass plus the err_* flags) is sticky until reset.
//   The optional stall watchdog is enabled by defining SORT_CHK_TIMEOUT_EN.
//   Without it, err_timeout is tied to 0 and a stalled sorter leaves done low.
module sort_output_checker #(
  parameter int N       = 5,
  parameter int W       = 32,
  parameter int SW      = 40,
  parameter int TIMEOUT = 64
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         in_en,
  input  logic [W-1:0] in_x,
  input  logic         out_rdy,
  input  logic [W-1:0] out_y,
  output logic         get_en,
  output logic         done,
  output logic         pass,
  output logic         err_order,
  output logic         err_count,
  output logic         err_sum,
  output logic         err_timeout,
  output logic [7:0]   out_cnt
);

  // Elaboration-time guards: the sums must never wrap, and the counts must fit in 8 bits.
  if (SW < W + $clog2(N + 1)) begin : g_sw_too_narrow
    $error("sort_output_checker: SW must be at least W + clog2(N+1)");
  end
  if (N < 1 || N > 255 || TIMEOUT < 1) begin : g_bad_limits
    $error("sort_output_checker: N must be 1..255 and TIMEOUT must be >= 1");
  end

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam logic [7:0] N_C    = 8'(N);
  localparam logic [7:0] N_M1_C = 8'(N - 1);

  state_t          state_r, state_nxt;
  logic [7:0]      in_cnt_r, in_cnt_nxt;
  logic [7:0]      out_cnt_r, out_cnt_nxt;
  logic [SW-1:0]   sum_in_r, sum_in_nxt;
  logic [SW-1:0]   sum_out_r, sum_out_nxt;
  logic [W-1:0]    prev_y_r, prev_y_nxt;
  logic            done_r, done_nxt;
  logic            pass_r, pass_nxt;
  logic            err_order_r, err_order_nxt;
  logic            err_count_r, err_count_nxt;
  logic            err_sum_r, err_sum_nxt;

  logic            running_s;
  logic            get_s;
  logic            put_ok_s;
  logic            put_ovf_s;
  logic            last_get_s;
  logic            order_bad_s;
  logic            early_s;
  logic            timeout_s;
  logic            err_to_s;

  // Decode this cycle's put/get events from the current state and inputs.
  always_comb begin
    running_s  = (state_r == ST_RUN);
    get_s      = out_rdy && running_s && (out_cnt_r < N_C);
    put_ok_s   = running_s && in_en && (in_cnt_r < N_C);
    put_ovf_s  = running_s && in_en && (in_cnt_r >= N_C);
    last_get_s = get_s && (out_cnt_r == N_M1_C);
  end

`ifdef SORT_CHK_TIMEOUT_EN
  localparam int            WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] TO_M1_C = WDW'(TIMEOUT - 1);

  logic [WDW-1:0] wdog_r, wdog_nxt;
  logic           err_timeout_r;

  // Watchdog: restarts on any traffic, counts idle cycles once a put has been seen.
  always_comb begin
    wdog_nxt  = wdog_r;
    timeout_s = 1'b0;
    if (!running_s) begin
      wdog_nxt = wdog_r;
    end else if (in_en || get_s) begin
      wdog_nxt = '0;
    end else if (in_cnt_r != 8'd0) begin
      wdog_nxt  = wdog_r + WDW'(1'b1);
      timeout_s = (wdog_r == TO_M1_C);
    end else begin
      wdog_nxt = wdog_r;
    end
  end

  // Watchdog register and its sticky flag.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wdog_r        <= '0;
      err_timeout_r <= 1'b0;
    end else begin
      wdog_r        <= wdog_nxt;
      err_timeout_r <= err_timeout_r | timeout_s;
    end
  end

  assign err_to_s    = err_timeout_r;
  assign err_timeout = err_timeout_r;
`else
  assign timeout_s   = 1'b0;
  assign err_to_s    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next-state: accumulate puts and gets, raise error flags, settle the verdict.
  always_comb begin
    state_nxt     = state_r;
    in_cnt_nxt    = in_cnt_r;
    out_cnt_nxt   = out_cnt_r;
    sum_in_nxt    = sum_in_r;
    sum_out_nxt   = sum_out_r;
    prev_y_nxt    = prev_y_r;
    done_nxt      = done_r;
    pass_nxt      = pass_r;
    err_sum_nxt   = err_sum_r;
    order_bad_s   = 1'b0;
    early_s       = 1'b0;

    // A same-cycle put is counted before the get's count check below.
    if (put_ok_s) begin
      in_cnt_nxt = in_cnt_r + 8'd1;
      sum_in_nxt = sum_in_r + SW'(in_x);
    end else begin
      in_cnt_nxt = in_cnt_r;
      sum_in_nxt = sum_in_r;
    end

    if (get_s) begin
      sum_out_nxt = sum_out_r + SW'(out_y);
      prev_y_nxt  = out_y;
      out_cnt_nxt = out_cnt_r + 8'd1;
      order_bad_s = (out_cnt_r != 8'd0) && (out_y < prev_y_r);
      early_s     = (out_cnt_r >= in_cnt_nxt);
    end else begin
      sum_out_nxt = sum_out_r;
      prev_y_nxt  = prev_y_r;
      out_cnt_nxt = out_cnt_r;
    end

    err_order_nxt = err_order_r | order_bad_s;
    err_count_nxt = err_count_r | put_ovf_s | early_s;

    case (state_r)
      ST_RUN: begin
        if (last_get_s) begin
          state_nxt   = ST_DONE;
          done_nxt    = 1'b1;
          err_sum_nxt = (sum_in_nxt != sum_out_nxt);
          pass_nxt    = !err_order_nxt && !err_count_nxt && !err_sum_nxt &&
                        !err_to_s && (in_cnt_nxt == N_C);
        end else if (timeout_s) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
          pass_nxt  = 1'b0;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt = ST_DONE;
      end
      default: begin
        state_nxt = ST_DONE;
        done_nxt  = 1'b1;
        pass_nxt  = 1'b0;
      end
    endcase
  end

  // State and accumulator registers; a synchronous reset discards any partial batch.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r     <= ST_RUN;
      in_cnt_r    <= 8'd0;
      out_cnt_r   <= 8'd0;
      sum_in_r    <= '0;
      sum_out_r   <= '0;
      prev_y_r    <= '0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_order_r <= 1'b0;
      err_count_r <= 1'b0;
      err_sum_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      in_cnt_r    <= in_cnt_nxt;
      out_cnt_r   <= out_cnt_nxt;
      sum_in_r    <= sum_in_nxt;
      sum_out_r   <= sum_out_nxt;
      prev_y_r    <= prev_y_nxt;
      done_r      <= done_nxt;
      pass_r      <= pass_nxt;
      err_order_r <= err_order_nxt;
      err_count_r <= err_count_nxt;
      err_sum_r   <= err_sum_nxt;
    end
  end

  assign get_en    = get_s;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_order = err_order_r;
  assign err_count = err_count_r;
  assign err_sum   = err_sum_r;
  assign out_cnt   = out_cnt_r;

endmodule

// File: tb/tb_sort_output_checker.sv
// Self-checking bench for sort_output_checker: a table of directed cycles,
// hand-written corner sequences, and randomized batches scored against a
// queue-based reference model.
module tb_sort_output_checker;

  localparam int N       = 5;
  localparam int W       = 32;
  localparam int TIMEOUT = 64;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         in_en = 1'b0;
  logic [W-1:0] in_x = '0;
  logic         out_rdy = 1'b0;
  logic [W-1:0] out_y = '0;
  logic         get_en, done, pass, err_order, err_count, err_sum, err_timeout;
  logic [7:0]   out_cnt;

  sort_output_checker #(.N(N), .W(W), .SW(40), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_en(in_en), .in_x(in_x), .out_rdy(out_rdy),
    .out_y(out_y), .get_en(get_en), .done(done), .pass(pass),
    .err_order(err_order), .err_count(err_count), .err_sum(err_sum),
    .err_timeout(err_timeout), .out_cnt(out_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (batch-level view) ----------------
  int unsigned m_ins[$];
  int unsigned m_outs[$];
  bit m_done, m_eo, m_ec, m_es, m_pass, m_to;
  int m_idle;

  function automatic longint unsigned qsum(input int unsigned q[$]);
    longint unsigned s = 0;
    foreach (q[i]) s += longint'(q[i]);
    return s;
  endfunction

  task automatic model_reset();
    m_ins.delete(); m_outs.delete();
    m_done = 0; m_eo = 0; m_ec = 0; m_es = 0; m_pass = 0; m_to = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit en, input int unsigned x, input bit g, input int unsigned y);
    if (m_done) return;
    if (en || g) m_idle = 0;
    else if (m_ins.size() > 0) m_idle++;
    if (en) begin
      if (m_ins.size() < N) m_ins.push_back(x);
      else m_ec = 1;
    end
    if (g) begin
      if (m_outs.size() > 0 && y < m_outs[$]) m_eo = 1;
      if (m_outs.size() >= m_ins.size()) m_ec = 1;
      m_outs.push_back(y);
      if (m_outs.size() == N) begin
        m_done = 1;
        m_es   = (qsum(m_ins) != qsum(m_outs));
        m_pass = !m_eo && !m_ec && !m_es && !m_to && (m_ins.size() == N);
      end
    end
`ifdef SORT_CHK_TIMEOUT_EN
    if (!m_done && m_idle == TIMEOUT) begin
      m_to = 1; m_done = 1; m_pass = 0;
    end
`endif
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".done"},        done,        m_done);
    chk({tag, ".pass"},        pass,        m_pass);
    chk({tag, ".err_order"},   err_order,   m_eo);
    chk({tag, ".err_count"},   err_count,   m_ec);
    chk({tag, ".err_sum"},     err_sum,     m_es);
    chk({tag, ".err_timeout"}, err_timeout, m_to);
    chk({tag, ".out_cnt"},     out_cnt,     64'(m_outs.size()));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".get_en"},      get_en,      0);
    chk({tag, ".done"},        done,        0);
    chk({tag, ".pass"},        pass,        0);
    chk({tag, ".err_order"},   err_order,   0);
    chk({tag, ".err_count"},   err_count,   0);
    chk({tag, ".err_sum"},     err_sum,     0);
    chk({tag, ".err_timeout"}, err_timeout, 0);
    chk({tag, ".out_cnt"},     out_cnt,     0);
  endtask

  // Reset for one edge; leaves the bench at posedge+1 with RST_N high.
  task automatic do_reset();
    RST_N = 1'b0; in_en = 1'b0; out_rdy = 1'b0; in_x = '0; out_y = '0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    model_reset();
  endtask

  // One clock cycle with model scoring: get_en checked mid-cycle, state after the edge.
  task automatic run_cyc(input bit en, input int unsigned x, input bit rdy,
                         input int unsigned y, input string tag, output bit took);
    bit exp_g;
    in_en = en; in_x = x; out_rdy = rdy; out_y = y;
    @(negedge CLK);
    exp_g = rdy && !m_done && (m_outs.size() < N);
    chk({tag, ".get_en"}, get_en, exp_g);
    took = exp_g;
    @(posedge CLK);
    model_step(en, x, exp_g, y);
    #1;
    compare_model(tag);
  endtask

  typedef int unsigned arr5_t[5];
  arr5_t nom_in  = '{32'd1, 32'd142, 32'd71, 32'd173, 32'd216};
  arr5_t nom_out = '{32'd1, 32'd71, 32'd142, 32'd173, 32'd216};

  task automatic put_all(input string tag);
    bit t;
    for (int i = 0; i < N; i++) run_cyc(1'b1, nom_in[i], 1'b0, 32'd0, tag, t);
  endtask

  task automatic get_range(input arr5_t a, input int lo, input int hi, input string tag);
    bit t;
    for (int i = lo; i <= hi; i++) run_cyc(1'b0, 32'd0, 1'b1, a[i], tag, t);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          rst;
    bit          en;
    logic [31:0] x;
    bit          rdy;
    logic [31:0] y;
    bit          g, d, p, eo, ec, es;
    int          cnt;
  } vec_t;
  vec_t tq[$];

  task automatic add_row(input bit r, input bit en, input logic [31:0] x, input bit rdy,
                         input logic [31:0] y, input bit g, input bit d, input bit p,
                         input bit eo, input bit ec, input bit es, input int cnt);
    vec_t v;
    v.rst = r; v.en = en; v.x = x; v.rdy = rdy; v.y = y;
    v.g = g; v.d = d; v.p = p; v.eo = eo; v.ec = ec; v.es = es; v.cnt = cnt;
    tq.push_back(v);
  endtask

  // Randomized-batch scratch state.
  int unsigned r_vals[$];
  int unsigned r_outs[$];

  initial begin
    bit t;
    int mode, nput, pi, gi, cyc, k;
    int unsigned tmp;

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset");
    RST_N = 1'b1;

    // Nominal batch, then an out-of-order batch.
    add_row(1, 1, 32'd1,   0, 32'd0,   0, 0, 0, 0, 0, 0, 0);
    add_row(0, 1, 32'd142, 0, 32'd0,   0, 0, 0, 0, 0, 0, 0);
    add_row(0, 1, 32'd71,  0, 32'd0,   0, 0, 0, 0, 0, 0, 0);
    add_row(0, 1, 32'd173, 0, 32'd0,   0, 0, 0, 0, 0, 0, 0);
    add_row(0, 1, 32'd216, 0, 32'd0,   0, 0, 0, 0, 0, 0, 0);
    add_row(0, 0, 32'd0,   1, 32'd1,   1, 0, 0, 0, 0, 0, 1);
    add_row(0, 0, 32'd0,   1, 32'd71,  1, 0, 0, 0, 0, 0, 2);
    add_row(0, 0, 32'd0,   1, 32'd142, 1, 0, 0, 0, 0, 0, 3);
    add_row(0, 0, 32'd0,   1, 32'd173, 1, 0, 0, 0, 0, 0, 4);
    add_row(0, 0, 32'd0,   1, 32'd216, 1, 1, 1, 0, 0, 0, 5);
    add_row(0, 0, 32'd0,   1, 32'd9,   0, 1, 1, 0, 0, 0, 5);
    add_row(1, 1, 32'd1,   0, 32'd0,   0, 0, 0, 0, 0, 0, 0);
    add_row(0, 1, 32'd142, 0, 32'd0,   0, 0, 0, 0, 0, 0, 0);
    add_row(0, 1, 32'd71,  0, 32'd0,   0, 0, 0, 0, 0, 0, 0);
    add_row(0, 1, 32'd173, 0, 32'd0,   0, 0, 0, 0, 0, 0, 0);
    add_row(0, 1, 32'd216, 0, 32'd0,   0, 0, 0, 0, 0, 0, 0);
    add_row(0, 0, 32'd0,   1, 32'd1,   1, 0, 0, 0, 0, 0, 1);
    add_row(0, 0, 32'd0,   1, 32'd142, 1, 0, 0, 0, 0, 0, 2);
    add_row(0, 0, 32'd0,   1, 32'd71,  1, 0, 0, 1, 0, 0, 3);
    add_row(0, 0, 32'd0,   1, 32'd173, 1, 0, 0, 1, 0, 0, 4);
    add_row(0, 0, 32'd0,   1, 32'd216, 1, 1, 0, 1, 0, 0, 5);

    for (int i = 0; i < tq.size(); i++) begin
      if (tq[i].rst) do_reset();
      in_en = tq[i].en; in_x = tq[i].x; out_rdy = tq[i].rdy; out_y = tq[i].y;
      @(negedge CLK);
      chk($sformatf("tbl%0d.get_en", i), get_en, tq[i].g);
      @(posedge CLK); #1;
      chk($sformatf("tbl%0d.done", i),      done,        tq[i].d);
      chk($sformatf("tbl%0d.pass", i),      pass,        tq[i].p);
      chk($sformatf("tbl%0d.err_order", i), err_order,   tq[i].eo);
      chk($sformatf("tbl%0d.err_count", i), err_count,   tq[i].ec);
      chk($sformatf("tbl%0d.err_sum", i),   err_sum,     tq[i].es);
      chk($sformatf("tbl%0d.err_to", i),    err_timeout, 1'b0);
      chk($sformatf("tbl%0d.out_cnt", i),   out_cnt,     8'(tq[i].cnt));
    end

    // Sum fault: last output off by one.
    do_reset();
    put_all("sum");
    nom_out[4] = 32'd217;
    get_range(nom_out, 0, 4, "sum");
    nom_out[4] = 32'd216;
    chk("sum.err_sum_set", err_sum, 1'b1);
    chk("sum.err_order_clr", err_order, 1'b0);
    chk("sum.pass_low", pass, 1'b0);

    // Early output before any put.
    do_reset();
    run_cyc(1'b0, 32'd0, 1'b1, 32'd5, "early", t);
    chk("early.err_count_set", err_count, 1'b1);
    put_all("early");
    get_range(nom_out, 1, 4, "early");
    chk("early.done_set", done, 1'b1);
    chk("early.pass_low", pass, 1'b0);

    // Overflow: the sixth put flags err_count.
    do_reset();
    put_all("ovf");
    chk("ovf.five_ok", err_count, 1'b0);
    run_cyc(1'b1, 32'd7, 1'b0, 32'd0, "ovf", t);
    chk("ovf.sixth_err", err_count, 1'b1);

    // Same-cycle put and get with in_cnt 4->5 and out_cnt 4.
    do_reset();
    for (int i = 0; i < 4; i++) run_cyc(1'b1, nom_in[i], 1'b0, 32'd0, "simul", t);
    get_range(nom_out, 0, 3, "simul");
    run_cyc(1'b1, 32'd216, 1'b1, 32'd216, "simul", t);
    chk("simul.err_count_clr", err_count, 1'b0);
    chk("simul.done", done, 1'b1);
    chk("simul.pass", pass, 1'b1);

    // Reset mid-batch after three gets, then a clean batch.
    do_reset();
    put_all("midrst");
    get_range(nom_out, 0, 2, "midrst");
    do_reset();
    check_zero("midrst_after");
    put_all("midrst2");
    get_range(nom_out, 0, 4, "midrst2");
    chk("midrst2.pass", pass, 1'b1);

`ifdef SORT_CHK_TIMEOUT_EN
    // Watchdog: five puts then a silent sorter.
    do_reset();
    put_all("wdog");
    for (int i = 0; i < TIMEOUT - 1; i++) run_cyc(1'b0, 32'd0, 1'b0, 32'd0, "wdog", t);
    chk("wdog.not_yet", done, 1'b0);
    run_cyc(1'b0, 32'd0, 1'b0, 32'd0, "wdog", t);
    chk("wdog.err_timeout", err_timeout, 1'b1);
    chk("wdog.done", done, 1'b1);
    chk("wdog.pass", pass, 1'b0);
`endif

    // Randomized batches against the model.
    for (int b = 0; b < 30; b++) begin
      do_reset();
      r_vals.delete(); r_outs.delete();
      mode = $urandom_range(0, 4);
      nput = ((b % 7) == 3) ? N + 1 : N;
      for (int i = 0; i < nput; i++)
        r_vals.push_back((b % 2 == 0) ? $urandom_range(0, 20) : $urandom);
      for (int i = 0; i < N; i++) r_outs.push_back(r_vals[i]);
      for (int i = 1; i < N; i++) begin
        k = i;
        while (k > 0 && r_outs[k-1] > r_outs[k]) begin
          tmp = r_outs[k]; r_outs[k] = r_outs[k-1]; r_outs[k-1] = tmp; k--;
        end
      end
      if (mode == 2) begin
        k = $urandom_range(0, N - 2);
        tmp = r_outs[k]; r_outs[k] = r_outs[k+1]; r_outs[k+1] = tmp;
      end else if (mode == 3) begin
        k = $urandom_range(0, N - 1);
        r_outs[k] = r_outs[k] + 32'd1;
      end
      pi = 0; gi = 0; cyc = 0;
      while ((pi < nput || gi < N) && cyc < 300) begin
        bit en, rdy;
        en  = (pi < nput) && ($urandom_range(0, 1) == 1);
        rdy = (gi < N) && (pi >= nput || mode == 4) && ($urandom_range(0, 2) != 0);
        run_cyc(en, en ? r_vals[pi] : $urandom, rdy, rdy ? r_outs[gi] : $urandom,
                $sformatf("rnd%0d", b), t);
        if (en) pi++;
        if (t) gi++;
        cyc++;
      end
      run_cyc(1'b0, 32'd0, 1'b1, $urandom, $sformatf("rnd%0d_tail", b), t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
